// File: rtl/snapshot_capture_ctrl_if.sv
// BRAM write-port bundle driven by the snapshot capture sequencer.
// The master side drives address, data and write enable; the slave side is the BRAM.
`timescale 1ns/1ps
interface snapshot_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;

  modport master (output bram_addr, output bram_din, output bram_we);
  modport slave  (input  bram_addr, input  bram_din, input  bram_we);
endinterface

// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture sequencer: arms on a software edge of ctrl_word[0], waits for a trigger,
// writes a qualified window of samples into BRAM and publishes done/busy/count status.
`timescale 1ns/1ps
module snapshot_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic [31:0]            ctrl_word,
  input  logic                   trig_in,
  input  logic                   we_in,
  input  logic [DATA_W-1:0]      din,
  snapshot_capture_ctrl_if.master bram,
  output logic [31:0]            status
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_reg, state_next;
  logic                arm_q_reg;
  logic [ADDR_W:0]     count_reg, count_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic                bram_we_reg;
  logic [ADDR_W-1:0]   bram_addr_reg;
  logic [DATA_W-1:0]   bram_din_reg;
  logic [31:0]         status_reg, status_next;

  logic                arm_bit, trig_sel, we_sel, circular;
  logic                arm_edge, valid, trig_hit;
  logic                wr_en;
  logic [ADDR_W:0]     cnt_inc;
  logic                busy_next, done_next;
  logic                ctrl_unused;

  assign arm_bit     = ctrl_word[0];
  assign trig_sel    = ctrl_word[1];
  assign we_sel      = ctrl_word[2];
  assign circular    = ctrl_word[3];
  assign ctrl_unused = ^ctrl_word[31:4];

  // arm_q resets high so an arm bit held through reset is not seen as a new edge.
  assign arm_edge = arm_bit & ~arm_q_reg;
  assign valid    = ~we_sel | we_in;
  assign trig_hit = ~trig_sel | trig_in;

  // Count saturates at the window size so circular captures report a full buffer.
  assign cnt_inc = (count_reg == CNT_FULL) ? CNT_FULL : (count_reg + 1'b1);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    wr_en      = 1'b0;

    if (arm_edge) begin
      state_next = ST_ARMED;
      count_next = '0;
      ptr_next   = '0;
    end else begin
      case (state_reg)
        ST_ARMED: begin
          if (trig_hit) begin
            state_next = ST_CAPTURE;
            wr_en      = valid;
          end
        end
        ST_CAPTURE: begin
          if (circular && !arm_bit) begin
            state_next = ST_DONE;
          end else begin
            wr_en = valid;
          end
        end
        default: begin
        end
      endcase
    end

    if (wr_en) begin
      count_next = cnt_inc;
      ptr_next   = ptr_reg + 1'b1;
      if (!circular && (cnt_inc == CNT_FULL)) begin
        state_next = ST_DONE;
      end
    end
  end

  // done lags the final write pulse by one cycle; busy follows the next state directly.
  assign busy_next = (state_next == ST_ARMED) || (state_next == ST_CAPTURE);
  assign done_next = (state_reg == ST_DONE) && (state_next == ST_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_status
      if (gi == 31) begin : g_done
        assign status_next[gi] = done_next;
      end else if (gi == 30) begin : g_busy
        assign status_next[gi] = busy_next;
      end else if (gi <= ADDR_W) begin : g_count
        assign status_next[gi] = count_next[gi];
      end else begin : g_zero
        assign status_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg     <= ST_IDLE;
      arm_q_reg     <= 1'b1;
      count_reg     <= '0;
      ptr_reg       <= '0;
      bram_we_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      status_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      arm_q_reg   <= arm_bit;
      count_reg   <= count_next;
      ptr_reg     <= ptr_next;
      bram_we_reg <= wr_en;
      status_reg  <= status_next;
      if (wr_en) begin
        bram_addr_reg <= ptr_reg;
        bram_din_reg  <= din;
      end
    end
  end

  assign bram.bram_we   = bram_we_reg;
  assign bram.bram_addr = bram_addr_reg;
  assign bram.bram_din  = bram_din_reg;
  assign status         = status_reg;

endmodule
